// File: rtl/uart_rx_sipo.sv
// uart_rx_sipo: oversampled UART receiver (start, 8 data LSB first, parity, stop) with error flags.
module uart_rx_sipo #(
  parameter int OVERSAMPLE = 16,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       baud_tick,
  input  logic       serial_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_err,
  output logic       framing_err,
  output logic       busy
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;
  state_t state, state_n;
  logic [1:0] sync;
  logic rx_s, at_half, at_last;
  logic [TW-1:0] tick_cnt, tick_n;
  logic [2:0] bit_cnt, bit_n;
  logic [7:0] shift, shift_n, data_n;
  logic par_bit, par_n, valid_n, perr_n, ferr_n;
  assign rx_s = sync[1];
  assign at_half = baud_tick && tick_cnt == HALF;
  assign at_last = baud_tick && tick_cnt == LAST;
  assign busy = state != IDLE;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sync        <= 2'b11;
      state       <= IDLE;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      par_bit     <= 1'b0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      parity_err  <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      sync        <= {sync[0], serial_in};
      state       <= state_n;
      tick_cnt    <= tick_n;
      bit_cnt     <= bit_n;
      shift       <= shift_n;
      par_bit     <= par_n;
      data_out    <= data_n;
      data_valid  <= valid_n;
      parity_err  <= perr_n;
      framing_err <= ferr_n;
    end
  always_comb begin
    state_n = state;
    tick_n  = baud_tick ? tick_cnt + 1'b1 : tick_cnt;
    bit_n   = bit_cnt;
    shift_n = shift;
    par_n   = par_bit;
    data_n  = data_out;
    valid_n = 1'b0;
    perr_n  = parity_err;
    ferr_n  = framing_err;
    case (state)
      IDLE: begin
        tick_n = '0;
        if (baud_tick && !rx_s) state_n = START;
      end
      START: if (at_half) begin
        state_n = rx_s ? IDLE : DATA;
        tick_n  = '0;
        bit_n   = '0;
      end
      DATA: if (at_last) begin
        shift_n = {rx_s, shift[7:1]};
        tick_n  = '0;
        bit_n   = bit_cnt + 1'b1;
        state_n = bit_cnt == 3'd7 ? PARITY : DATA;
      end
      PARITY: if (at_last) begin
        par_n   = rx_s;
        tick_n  = '0;
        state_n = STOP;
      end
      STOP: if (at_last) begin
        data_n  = shift;
        valid_n = 1'b1;
        perr_n  = (^shift ^ par_bit) != PARITY_ODD;
        ferr_n  = !rx_s;
        tick_n  = '0;
        state_n = rx_s ? IDLE : BRK;
      end
      BRK: begin
        tick_n = '0;
        if (baud_tick && rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule
